pll_lock_supervisor: RTL

- Sequences the 50 MHz-input PLL (CLKOUT0 = 200 MHz) through power-up, reset, lock acquisition and lock qualification.
- Holds the downstream system reset until lock has been stable for a programmable time.
- Detects lock loss and retries a bounded number of times before reporting failure.
- Runs on the free-running PLL input clock, never on the PLL output; drives the PLL RESET/PLLPWD pins and the PLL-domain reset request.

---
 rtl/pll_ctrl_pkg.sv | 63 ++++++
 rtl/sync_2ff.sv | 26 ++
 rtl/pll_lock_supervisor.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/pll_ctrl_pkg.sv
// Shared PLL control definitions: FSM state encoding, default timing constants, pin decode.
// Latency: combinational helpers only, no state.
// Backpressure: none; constants and pure functions.
package pll_ctrl_pkg;

    // State encoding is also the status-register encoding, so these codes are fixed
    typedef enum logic [2:0] {
        ST_OFF    = 3'd0,
        ST_RESET  = 3'd1,
        ST_WAIT   = 3'd2,
        ST_STABLE = 3'd3,
        ST_RUN    = 3'd4,
        ST_FAIL   = 3'd5
    } pll_state_t;

    // Defaults sized for a 50 MHz reference clock
    localparam int DEF_RST_CYCLES   = 16;
    localparam int DEF_LOCK_TIMEOUT = 50000;
    localparam int DEF_LOCK_STABLE  = 1024;
    localparam int DEF_LOSS_FILTER  = 4;
    localparam int DEF_MAX_RETRIES  = 3;
    localparam int DEF_CNT_W        = 16;

    // Pin levels driven while in a given state
    typedef struct packed {
        logic pwd;
        logic reset;
        logic sys_rst;
        logic ready;
        logic fail;
    } pll_pins_t;

    // Invalid codes decode like OFF: PLL parked, everything held in reset
    function automatic pll_pins_t decode_pins(input pll_state_t s);
        pll_pins_t p;
        p.pwd     = 1'b1;
        p.reset   = 1'b1;
        p.sys_rst = 1'b1;
        p.ready   = 1'b0;
        p.fail    = 1'b0;
        case (s)
            ST_RESET: begin
                p.pwd = 1'b0;
            end
            ST_WAIT, ST_STABLE: begin
                p.pwd   = 1'b0;
                p.reset = 1'b0;
            end
            ST_RUN: begin
                p.pwd     = 1'b0;
                p.reset   = 1'b0;
                p.sys_rst = 1'b0;
                p.ready   = 1'b1;
            end
            ST_FAIL: begin
                p.fail = 1'b1;
            end
            default: ;
        endcase
        return p;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Generic two-flop synchronizer for a single asynchronous level into clk.
// Latency: 2 clk cycles from a stable input to q.
// Backpressure: none; level signal, no handshake.
module sync_2ff #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    // First flop may go metastable; second flop gives it a full cycle to settle
    always_ff @(posedge clk) begin
        if (rst) begin
            meta <= RST_VAL;
            q    <= RST_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/pll_lock_supervisor.sv
// PLL power-up / reset / lock-qualification sequencer with bounded retries and lock-loss detection.
// Latency: rst release to ready >= 1 + RST_CYCLES + 2 + 1 + LOCK_STABLE cycles; outputs registered.
// Backpressure: none; free-running control block, restart is a single-cycle pulse.
module pll_lock_supervisor
    import pll_ctrl_pkg::*;
#(
    parameter int RST_CYCLES   = DEF_RST_CYCLES,
    parameter int LOCK_TIMEOUT = DEF_LOCK_TIMEOUT,
    parameter int LOCK_STABLE  = DEF_LOCK_STABLE,
    parameter int LOSS_FILTER  = DEF_LOSS_FILTER,
    parameter int MAX_RETRIES  = DEF_MAX_RETRIES,
    parameter int CNT_W        = DEF_CNT_W
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       enable,
    input  logic       restart,
    input  logic       lock,
    output logic       pll_pwd,
    output logic       pll_reset,
    output logic       sys_rst,
    output logic       ready,
    output logic       fail,
    output logic [1:0] retry_cnt,
    output logic [2:0] state
);

    localparam int LOSS_W = $clog2(LOSS_FILTER + 1);

    // Counter load values: the counter runs N-1 down to 0, giving N cycles in the state
    localparam logic [CNT_W-1:0]  RST_LOAD  = CNT_W'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0]  TMO_LOAD  = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0]  STB_LOAD  = CNT_W'(LOCK_STABLE - 1);
    localparam logic [LOSS_W-1:0] LOSS_LAST = LOSS_W'(LOSS_FILTER - 1);

    pll_state_t        st;
    pll_state_t        st_nxt;
    logic [CNT_W-1:0]  cnt;
    logic [CNT_W-1:0]  cnt_nxt;
    logic [1:0]        retry_nxt;
    logic [LOSS_W-1:0] loss;
    logic [LOSS_W-1:0] loss_nxt;
    logic              lock_s;
    pll_pins_t         pins_nxt;

    sync_2ff #(
        .RST_VAL(1'b0)
    ) u_lock_sync (
        .clk(clk),
        .rst(rst),
        .d  (lock),
        .q  (lock_s)
    );

    // Outputs are decoded from the next state so they move with the state register
    assign pins_nxt = decode_pins(st_nxt);
    assign state    = st;

    // Next-state, counter, retry and lock-loss logic
    always_comb begin
        st_nxt    = st;
        cnt_nxt   = cnt;
        retry_nxt = retry_cnt;
        loss_nxt  = '0;
        if (!enable) begin
            // Power-down wins over restart and over any pending timeout
            st_nxt    = ST_OFF;
            cnt_nxt   = '0;
            retry_nxt = '0;
        end else begin
            case (st)
                ST_OFF: begin
                    st_nxt  = ST_RESET;
                    cnt_nxt = RST_LOAD;
                end
                ST_RESET: begin
                    if (cnt == '0) begin
                        st_nxt  = ST_WAIT;
                        cnt_nxt = TMO_LOAD;
                    end else begin
                        cnt_nxt = cnt - CNT_W'(1);
                    end
                end
                ST_WAIT: begin
                    if (lock_s) begin
                        st_nxt  = ST_STABLE;
                        cnt_nxt = STB_LOAD;
                    end else if (cnt == '0) begin
                        // Attempt timed out without lock
                        if ({30'd0, retry_cnt} < 32'(MAX_RETRIES)) begin
                            st_nxt    = ST_RESET;
                            cnt_nxt   = RST_LOAD;
                            retry_nxt = (retry_cnt == 2'd3) ? 2'd3 : retry_cnt + 2'd1;
                        end else begin
                            st_nxt  = ST_FAIL;
                            cnt_nxt = '0;
                        end
                    end else begin
                        cnt_nxt = cnt - CNT_W'(1);
                    end
                end
                ST_STABLE: begin
                    if (!lock_s) begin
                        // A glitch only restarts qualification; it is not a failed attempt
                        st_nxt  = ST_WAIT;
                        cnt_nxt = TMO_LOAD;
                    end else if (cnt == '0) begin
                        st_nxt  = ST_RUN;
                        cnt_nxt = '0;
                    end else begin
                        cnt_nxt = cnt - CNT_W'(1);
                    end
                end
                ST_RUN: begin
                    if (restart) begin
                        st_nxt    = ST_RESET;
                        cnt_nxt   = RST_LOAD;
                        retry_nxt = '0;
                    end else if (!lock_s) begin
                        if (loss == LOSS_LAST) begin
                            // Lock lost: re-sequence, retry budget untouched
                            st_nxt  = ST_RESET;
                            cnt_nxt = RST_LOAD;
                        end else begin
                            loss_nxt = loss + LOSS_W'(1);
                        end
                    end
                end
                ST_FAIL: begin
                    if (restart) begin
                        st_nxt    = ST_RESET;
                        cnt_nxt   = RST_LOAD;
                        retry_nxt = '0;
                    end
                end
                default: begin
                    // Unused codes fall back to the safe powered-down state
                    st_nxt    = ST_OFF;
                    cnt_nxt   = '0;
                    retry_nxt = '0;
                end
            endcase
        end
    end

    // State, counters and registered pin outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            st        <= ST_OFF;
            cnt       <= '0;
            retry_cnt <= '0;
            loss      <= '0;
            pll_pwd   <= 1'b1;
            pll_reset <= 1'b1;
            sys_rst   <= 1'b1;
            ready     <= 1'b0;
            fail      <= 1'b0;
        end else begin
            st        <= st_nxt;
            cnt       <= cnt_nxt;
            retry_cnt <= retry_nxt;
            loss      <= loss_nxt;
            pll_pwd   <= pins_nxt.pwd;
            pll_reset <= pins_nxt.reset;
            sys_rst   <= pins_nxt.sys_rst;
            ready     <= pins_nxt.ready;
            fail      <= pins_nxt.fail;
        end
    end

endmodule
